// File: rtl/uart_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and defaults for the UART transmit arbiter slice.
//   arb_state_e       : sequencer states (IDLE, START, WAIT_BUSY, WAIT_IDLE)
//   DEF_*             : default parameter values for uart_tx_arbiter
//   wrap_add()        : (a + b) mod n for small non-negative operands
// -----------------------------------------------------------------------------
package uart_arb_pkg;

  localparam int DEF_N_REQ          = 4;
  localparam int DEF_DATA_W         = 8;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } arb_state_e;

  // Operands are always below n, so one conditional subtract is enough.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage : uart_arb_pkg

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Scans req upward starting at rr_ptr,
// wrapping modulo N_REQ, and reports the first asserted index.
// Ports:
//   req     in  N_REQ  request vector
//   rr_ptr  in  ID_W   index with highest priority this round
//   win     out ID_W   selected index (0 when any_req is low)
//   any_req out 1      at least one request is asserted
// -----------------------------------------------------------------------------
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  win,
  output logic             any_req
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves it unassigned infers a latch.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_req && req[ID_W'(wrap_add(int'(rr_ptr), k, N_REQ))]) begin
        any_req = 1'b1;
        win     = ID_W'(wrap_add(int'(rr_ptr), k, N_REQ));
      end
    end
  end

endmodule : rr_pick

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between N_REQ byte producers. In IDLE the
// round-robin winner is granted, its byte latched, and a one-cycle start is
// issued next cycle; the transmitter's busy handshake is then tracked until
// the frame ends, after which priority moves to the requester after the one
// just served.
//
// Optional watchdog: define UART_ARB_TIMEOUT_EN to abort a frame whose busy
// edge never arrives within TIMEOUT_CYCLES (err pulse, no frame_done).
//
// Ports:
//   clk        in   system clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   req        in   N_REQ        per-requester request, held until granted
//   req_data   in   N_REQ*DATA_W packed bytes, requester i at [i*DATA_W +: DATA_W]
//   grant      out  N_REQ        one-hot pulse in the capture cycle
//   tx_start   out  1            one-cycle transmitter start strobe
//   tx_data    out  DATA_W       byte being sent, held until next grant
//   tx_busy    in   1            transmitter busy
//   active_id  out  ID_W         requester being served
//   frame_done out  1            pulse when tx_busy falls for the served frame
//   err        out  1            watchdog abort pulse (0 without the macro)
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ          = DEF_N_REQ,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ID_W           = $clog2(N_REQ),
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic [ID_W-1:0]         active_id,
  output logic                    frame_done,
  output logic                    err
);

  arb_state_e      state, state_nxt;
  logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0] win;
  logic            any_req;
  logic            capture;
  logic            timeout_hit;
  logic [ID_W-1:0] next_id;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win     (win),
    .any_req (any_req)
  );

  // Priority for the next round starts just after the requester served now.
  assign next_id = ID_W'(wrap_add(int'(active_id), 1, N_REQ));

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt;

  // Counts cycles spent in the current wait state; any state change restarts it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt <= '0;
    end else if (state_nxt != state) begin
      wd_cnt <= '0;
    end else if (state == WAIT_BUSY || state == WAIT_IDLE) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog compiled out: the sequencer waits on the transmitter forever.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant      = '0;
    capture    = 1'b0;
    tx_start   = 1'b0;
    frame_done = 1'b0;
    err        = 1'b0;

    unique case (state)
      IDLE: begin
        // grant is a same-cycle decode of req; gating with n_rst keeps every
        // output at 0 while reset is held even if producers keep requesting.
        if (any_req && n_rst) begin
          grant[win] = 1'b1;
          capture    = 1'b1;
          state_nxt  = START;
        end
      end

      START: begin
        tx_start  = 1'b1;
        state_nxt = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_IDLE;
        end else if (timeout_hit) begin
          err        = 1'b1;
          rr_ptr_nxt = next_id;
          state_nxt  = IDLE;
        end
      end

      WAIT_IDLE: begin
        if (!tx_busy) begin
          frame_done = 1'b1;
          rr_ptr_nxt = next_id;
          state_nxt  = IDLE;
        end else if (timeout_hit) begin
          err        = 1'b1;
          rr_ptr_nxt = next_id;
          state_nxt  = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      tx_data   <= '0;
      active_id <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      if (capture) begin
        tx_data   <= req_data[int'(win)*DATA_W +: DATA_W];
        active_id <= win;
      end
    end
  end

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter (N_REQ=4, DATA_W=8). A small
// transmitter model answers tx_start with a busy pulse of frame_len cycles.
// Expected winners come from a rotate-and-find-lowest reference of the
// round-robin rule, with the priority pointer kept as a plain integer.
// Inputs change 1 time unit after a rising edge; outputs are read on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic          clk;
  logic          n_rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  grant;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy;
  logic [1:0]    active_id;
  logic          frame_done;
  logic          err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_ptr = 0;

  // transmitter model controls
  bit pend  = 0;
  bit stuck = 0;
  int busy_left = 0;
  int frame_len = 4;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .active_id  (active_id),
    .frame_done (frame_done),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter model: a start seen in a cycle raises busy right after that
  // cycle ends and keeps it high for frame_len cycles.
  initial forever begin
    @(negedge clk);
    if (tx_start === 1'b1 && !stuck) pend = 1;
  end

  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pend) begin
        busy_left = frame_len;
        pend = 0;
      end
      tx_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  end

  // grant must be one-hot whenever it is asserted.
  initial forever begin
    @(negedge clk);
    if (grant !== 4'b0000) begin
      checks++;
      if ($countones(grant) != 1) begin
        errors++;
        $display("FAIL grant_onehot: got %b want a single bit", grant);
      end
    end
  end

  // Reference: rotate the request mask so the pointer lands at bit 0, take the
  // lowest set bit, and rotate back.
  function automatic int model_pick(input logic [3:0] mask, input int ptr);
    logic [7:0] dbl;
    logic [3:0] rot;
    dbl = {mask, mask};
    rot = 4'(dbl >> ptr);
    for (int j = 0; j < 4; j++) if (rot[j]) return (ptr + j) % 4;
    return -1;
  endfunction

  // One complete transaction: present mask, expect the model's winner, its
  // byte at tx_start, and frame_done frame_len+1 cycles after tx_start.
  task automatic serve(input logic [3:0] mask, input logic [31:0] bytes,
                       input int flen, input bit hold,
                       output int won, output int gcyc);
    int t;
    int exp;
    logic [3:0] exp_g;
    logic [7:0] exp_byte;
    frame_len = flen;
    req_data  = bytes;
    req       = mask;
    exp       = model_pick(mask, exp_ptr);
    exp_g     = 4'b0001 << exp;
    exp_byte  = bytes[exp*8 +: 8];
    @(negedge clk);
    t = 0;
    while (grant === 4'b0000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    gcyc = cyc;
    won  = exp;
    checks++;
    if (grant !== exp_g) begin
      errors++;
      $display("FAIL serve_grant: got %b want %b (mask %b)", grant, exp_g, mask);
    end
    @(posedge clk);
    #1;
    if (!hold) req = req & ~exp_g;
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL serve_start: tx_start=%b grant=%b want 1 / 0000", tx_start, grant);
    end
    checks++;
    if (tx_data !== exp_byte || active_id !== 2'(exp)) begin
      errors++;
      $display("FAIL serve_data: tx_data=%h id=%0d want %h / %0d", tx_data, active_id, exp_byte, exp);
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (frame_done !== 1'b1 && t < flen + 40);
    checks++;
    if (t != flen + 1) begin
      errors++;
      $display("FAIL serve_frame_done: after %0d cycles want %0d", t, flen + 1);
    end
    checks++;
    if (tx_data !== exp_byte) begin
      errors++;
      $display("FAIL serve_hold_data: tx_data=%h want %h", tx_data, exp_byte);
    end
    exp_ptr = (exp + 1) % 4;
  endtask

  task automatic test_reset();
    req      = 4'b1111;
    req_data = 32'hDEADBEEF;
    n_rst    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({grant, tx_start, frame_done, err} !== 7'b0 || tx_data !== 8'h00 || active_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b start=%b done=%b err=%b data=%h id=%0d want all 0",
               grant, tx_start, frame_done, err, tx_data, active_id);
    end
    req = 4'b0000;
    @(posedge clk);
    #1;
    n_rst   = 1'b1;
    exp_ptr = 0;
  endtask

  task automatic test_single();
    int won, g;
    serve(4'b0100, 32'h00A5_0000, 10, 1'b0, won, g);
    @(negedge clk);
    checks++;
    if (active_id !== 2'd2 || tx_data !== 8'hA5 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL single_hold: id=%0d data=%h grant=%b want 2 / a5 / 0000", active_id, tx_data, grant);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int won, g, prev_g;
    int order [5] = '{0, 1, 2, 3, 0};
    exp_ptr = 0;
    // Bring the pointer to 0 first: requester 3 gets served alone.
    serve(4'b1000, 32'h1312_1110, 2, 1'b0, won, g);
    for (int i = 0; i < 5; i++) begin
      prev_g = g;
      serve(4'b1111, 32'h1312_1110, 5, 1'b1, won, g);
      checks++;
      if (won != order[i]) begin
        errors++;
        $display("FAIL b2b_order[%0d]: got %0d want %0d", i, won, order[i]);
      end
      if (i > 0) begin
        checks++;
        if (g - prev_g != 5 + 3) begin
          errors++;
          $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, g - prev_g, 8);
        end
      end
    end
    req = 4'b0000;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fairness();
    int won, g;
    serve(4'b0100, 32'h0405_0607, 3, 1'b0, won, g);
    serve(4'b1001, 32'h3300_0011, 3, 1'b0, won, g);
    checks++;
    if (won != 3) begin
      errors++;
      $display("FAIL fairness_ptr: got %0d want 3", won);
    end
    serve(4'b0001, 32'h3300_0011, 2, 1'b0, won, g);
    @(posedge clk);
    #1;
  endtask

  task automatic test_req_during_frame();
    int t;
    bit early;
    frame_len = 6;
    req_data  = 32'h0000_5A3C;
    req       = 4'b0001;
    @(negedge clk);
    t = 0;
    while (grant === 4'b0000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL midreq_first: got %b want 0001", grant);
    end
    @(posedge clk);
    #1;
    req = 4'b0000;
    t = 0;
    while (tx_busy !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    req = 4'b0010;
    early = 0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (grant !== 4'b0000) early = 1;
    end while (frame_done !== 1'b1 && t < 40);
    checks++;
    if (early || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL midreq_wait: early_grant=%0d frame_done=%b want 0 / 1", early, frame_done);
    end
    exp_ptr = 1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010) begin
      errors++;
      $display("FAIL midreq_grant: got %b want 0010", grant);
    end
    @(posedge clk);
    #1;
    req = 4'b0000;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (frame_done !== 1'b1 && t < 40);
    exp_ptr = 2;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_frame();
    int t, won, g;
    frame_len = 12;
    req_data  = 32'h0077_0000;
    req       = 4'b0100;
    t = 0;
    @(negedge clk);
    while (grant === 4'b0000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    req = 4'b0000;
    t = 0;
    while (tx_busy !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    #2;
    n_rst = 1'b0;
    req   = 4'b0110;
    busy_left = 0;
    pend  = 0;
    #1;
    checks++;
    if ({grant, tx_start, frame_done, err} !== 7'b0 || active_id !== 2'd0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: grant=%b start=%b done=%b err=%b id=%0d data=%h want all 0",
               grant, tx_start, frame_done, err, active_id, tx_data);
    end
    exp_ptr = 0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    serve(4'b0110, 32'h0022_1100, 3, 1'b0, won, g);
    checks++;
    if (won != 1) begin
      errors++;
      $display("FAIL reset_first_grant: got %0d want 1", won);
    end
    req = 4'b0000;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int won, g;
    logic [3:0] pending, mask, fresh;
    logic [31:0] bytes;
    pending = 4'b0000;
    bytes   = $urandom;
    for (int it = 0; it < 24; it++) begin
      fresh = 4'($urandom_range(0, 15));
      mask  = pending | fresh;
      if (mask == 4'b0000) mask = 4'b0001 << $urandom_range(0, 3);
      for (int k = 0; k < 4; k++)
        if (mask[k] && !pending[k]) bytes[k*8 +: 8] = 8'($urandom);
      serve(mask, bytes, $urandom_range(1, 7), 1'b0, won, g);
      pending = mask & ~(4'b0001 << won);
      @(posedge clk);
      #1;
    end
    req = 4'b0000;
    @(posedge clk);
    #1;
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int t, won, g;
    bit saw_done;
    stuck    = 1;
    req_data = 32'h0000_C300;
    req      = 4'b0010;
    exp_ptr  = model_pick(4'b0010, exp_ptr);
    @(negedge clk);
    t = 0;
    while (grant === 4'b0000 && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    req = 4'b0000;
    @(negedge clk);
    saw_done = 0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
      if (frame_done === 1'b1) saw_done = 1;
    end while (err !== 1'b1 && t < TO + 20);
    checks++;
    if (t != TO || saw_done) begin
      errors++;
      $display("FAIL timeout_err: err after %0d cycles want %0d, frame_done seen=%0d", t, TO, saw_done);
    end
    exp_ptr = 2;
    stuck = 0;
    @(posedge clk);
    #1;
    serve(4'b1111, 32'h4433_2211, 3, 1'b0, won, g);
    checks++;
    if (won != 2) begin
      errors++;
      $display("FAIL timeout_next: got %0d want 2", won);
    end
    req = 4'b0000;
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    n_rst    = 1'b0;
    req      = 4'b0000;
    req_data = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_req_during_frame();
    test_reset_mid_frame();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so a stuck handshake still ends the run.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: run exceeded its time budget");
    $fatal(1, "time budget exhausted");
  end

endmodule : tb_uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one UART transmitter between N_REQ byte producers.
- Latches the winning requester's byte and issues a one-cycle start to the transmitter.
- Tracks the transmitter's busy handshake until the frame completes, then grants the next requester.
- Sits between the producer blocks and the UART_Tx datapath, mirroring the UART_Rx receive path.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width sent to the transmitter
ID_W, $clog2(N_REQ), width of the requester index
TIMEOUT_CYCLES, 4096, watchdog limit in clk cycles (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all logic rising-edge
n_rst  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester request; held high with data stable until granted
req_data  input  N_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W]
grant  output  N_REQ  one-hot, one-cycle pulse; the winner's byte is captured that cycle
tx_start  output  1  one-cycle start strobe to the transmitter
tx_data  output  DATA_W  byte to transmit, stable from tx_start until frame end
tx_busy  input  1  transmitter busy, high while a frame is on the line
active_id  output  ID_W  index of the requester currently being served
frame_done  output  1  one-cycle pulse when tx_busy falls for the served frame
err  output  1  one-cycle watchdog abort pulse (tied 0 without the macro)

Behaviour:
- Reset (n_rst=0, asynchronous) values:
  - all outputs 0;
  - state=IDLE, round-robin pointer rr_ptr=0, watchdog count 0.
- Reset mid-frame aborts immediately; the transmitter frame in flight is not tracked afterwards.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_IDLE.
- IDLE:
  - If req is nonzero, choose the first asserted index scanning upward from rr_ptr, wrapping modulo N_REQ.
  - Same cycle: pulse grant[win], latch req_data slice into tx_data, set active_id=win, go to START.
  - If req is 0, stay in IDLE.
- START: tx_start=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for tx_busy=1, then go to WAIT_IDLE.
  - tx_busy already high on START exit counts as accepted.
- WAIT_IDLE:
  - On tx_busy=0: pulse frame_done, set rr_ptr=(active_id+1) mod N_REQ, go to IDLE.
- Latency: req to grant is 1 cycle when IDLE; grant to tx_start is 1 cycle; minimum gap between grants is frame length + 3 cycles.
- req is sampled only in IDLE. Requests arriving mid-frame wait.
- A requester holding req high after its grant is treated as presenting a new byte.
- Fairness: with all requesters active, grants rotate 0,1,..,N_REQ-1,0. Worst-case wait is N_REQ-1 frames.
- tx_data and active_id hold their values after frame_done until the next grant.
- Only one grant bit is ever high. grant is never asserted outside IDLE.
- rr_ptr wraps from N_REQ-1 to 0.

Optional Feature:
UART_ARB_TIMEOUT_EN:
- Defined:
  - A counter runs in WAIT_BUSY and WAIT_IDLE and clears on state entry.
  - On reaching TIMEOUT_CYCLES-1 without the awaited tx_busy edge, pulse err, advance rr_ptr past active_id, and return to IDLE. frame_done is not pulsed.
- Undefined: no counter; the FSM waits indefinitely; err is tied 0.

Decomposition:
- Package uart_arb_pkg:
  - state enum (IDLE, START, WAIT_BUSY, WAIT_IDLE);
  - default N_REQ, DATA_W and TIMEOUT_CYCLES constants.
- One combinational sub-module, rr_pick. Inputs: req, rr_ptr. Outputs: win index, any_req.
- FSM and data latch stay in uart_tx_arbiter.

Test Plan:
- Single requester: req=4'b0100, byte 0xA5, transmitter model busy 10 cycles → grant=4'b0100 one cycle; tx_start the next cycle with tx_data=0xA5; frame_done after busy falls; active_id=2.
- All four requesting continuously, bytes 0x10..0x13 → grant order 0,1,2,3,0; tx_data sequence 0x10,0x11,0x12,0x13,0x10; exactly one grant per frame.
- Fairness after pointer: rr_ptr=3 after serving requester 2; assert req=4'b1001 → requester 3 granted before 0.
- Request during frame: req[1] rises while in WAIT_IDLE → no grant until the cycle after frame_done; then grant=4'b0010.
- Reset mid-frame: pull n_rst low during WAIT_IDLE → tx_start, grant, frame_done, active_id all 0 immediately; after release, first grant goes to the lowest requesting index.
- Timeout (with UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): tx_busy stuck at 0 → err pulses 16 cycles after START exits; return to IDLE; next grant goes to the following requester; no frame_done.
